// File: rtl/ds_dec.sv
// Second-order CIC decimator recovering a DEPTH-bit volume word from a 1-bit
// first-order delta-sigma stream; decimates by 2^DEC_LOG in the clk domain.
module ds_dec #(
  parameter int DEPTH   = 12,
  parameter int DEC_LOG = 6
) (
  input  logic             clk,
  input  logic             map_rst,
  input  logic             snd_in,
  output logic [DEPTH-1:0] vol_out,
  output logic             vol_vld
);

  localparam int W = 2*DEC_LOG + 1;
  localparam logic [DEC_LOG-1:0] DCNT_ONE  = DEC_LOG'(1);
  localparam logic [DEC_LOG-1:0] DCNT_LAST = {DEC_LOG{1'b1}};
  localparam logic [1:0]         PRIME_MAX = 2'd2;

  logic [W-1:0]       i1_r, i2_r, snap_r, d1_r, d2_r, cic_r;
  logic [DEC_LOG-1:0] dcnt_r;
  logic               snap_vld_r, cic_vld_r;
  logic [1:0]         prime_r;

  logic [W-1:0]       i1_nxt_s, i2_nxt_s, c1_s, c2_s;
  logic               frame_end_s;
  logic [DEPTH-1:0]   vol_nxt_s;

  assign i1_nxt_s    = i1_r + {{(W-1){1'b0}}, snd_in};
  assign i2_nxt_s    = i2_r + i1_nxt_s;
  assign frame_end_s = (dcnt_r == DCNT_LAST);
  assign c1_s        = snap_r - d1_r;
  assign c2_s        = c1_s - d2_r;

  // Output scaling; the top bit of cic is set only by the all-ones frame code.
  always_comb begin
    vol_nxt_s = {DEPTH{1'b0}};
    if (cic_r[W-1]) begin
      vol_nxt_s = {DEPTH{1'b1}};
    end else begin
      vol_nxt_s = cic_r[2*DEC_LOG-1 -: DEPTH];
    end
  end

  // Integrators (modulo 2^W) and frame counter.
  always_ff @(posedge clk) begin
    if (map_rst) begin
      i1_r       <= {W{1'b0}};
      i2_r       <= {W{1'b0}};
      dcnt_r     <= {DEC_LOG{1'b0}};
      snap_r     <= {W{1'b0}};
      snap_vld_r <= 1'b0;
    end else begin
      i1_r       <= i1_nxt_s;
      i2_r       <= i2_nxt_s;
      dcnt_r     <= dcnt_r + DCNT_ONE;
      snap_vld_r <= frame_end_s;
      if (frame_end_s) begin
        snap_r <= i2_nxt_s;
      end
    end
  end

  // Comb stage, one clk after each snapshot.
  always_ff @(posedge clk) begin
    if (map_rst) begin
      d1_r      <= {W{1'b0}};
      d2_r      <= {W{1'b0}};
      cic_r     <= {W{1'b0}};
      cic_vld_r <= 1'b0;
    end else begin
      cic_vld_r <= snap_vld_r;
      if (snap_vld_r) begin
        d1_r  <= snap_r;
        d2_r  <= c1_s;
        cic_r <= c2_s;
      end
    end
  end

  // Output register; the first two frames after reset update vol_out silently.
  always_ff @(posedge clk) begin
    if (map_rst) begin
      vol_out <= {DEPTH{1'b0}};
      vol_vld <= 1'b0;
      prime_r <= 2'd0;
    end else begin
      vol_vld <= cic_vld_r && (prime_r == PRIME_MAX);
      if (cic_vld_r) begin
        vol_out <= vol_nxt_s;
        if (prime_r != PRIME_MAX) begin
          prime_r <= prime_r + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ds_dec.sv
// Scoreboard bench for ds_dec: stimulus pushes hand-computed per-frame results,
// a monitor pops and compares value and arrival cycle on every vol_vld.
module tb_ds_dec;

  logic        clk = 1'b0;
  logic        map_rst = 1'b1;
  logic        snd_in = 1'b0;
  logic [11:0] vol_out;
  logic        vol_vld;

  ds_dec #(.DEPTH(12), .DEC_LOG(6)) dut (
    .clk(clk), .map_rst(map_rst), .snd_in(snd_in),
    .vol_out(vol_out), .vol_vld(vol_vld)
  );

  always #5 clk = ~clk;

  typedef struct {int lo; int hi; int at;} exp_t;
  exp_t sbq[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // After the edge numbered p (0 = first sample after release), cyc holds p+1.
  always @(posedge clk) begin
    if (map_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (vol_vld !== 1'b0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_vld_at", cyc - 1, -1, -1);
        end else begin
          e = sbq.pop_front();
          chk("vol_out", int'(vol_out), e.lo, e.hi);
          chk("vld_cycle", cyc - 1, e.at, e.at);
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    map_rst = 1'b1;
    snd_in  = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_vol_out", int'(vol_out), 0, 0);
    chk("rst_vld", int'(vol_vld), 0, 0);
    map_rst = 1'b0;
  endtask

  // mode: 0 zeros, 1 ones, 2 alternating (ones on odd dcnt), 3 step at frame 10,
  // 4 first-order delta-sigma modulator of a 12-bit word (the DAC model).
  task automatic run(input int mode, input int nfr, input int vol);
    int   acc;
    int   s;
    logic b;
    exp_t e;
    acc = 0;
    for (int k = 0; k < nfr; k++) begin
      for (int o = 0; o < 64; o++) begin
        case (mode)
          0: b = 1'b0;
          1: b = 1'b1;
          2: b = (o % 2) == 1;
          3: b = (k >= 10);
          4: begin
            s   = acc + vol;
            b   = (s >= 4096);
            acc = s % 4096;
          end
          default: b = 1'b0;
        endcase
        snd_in = b;
        @(negedge clk);
      end
      if (k >= 2) begin
        e.at = 64*k + 65;
        case (mode)
          0: begin e.lo = 0; e.hi = 0; end
          1: begin e.lo = 4095; e.hi = 4095; end
          2: begin e.lo = 2048; e.hi = 2048; end
          3: begin
            // First frame of ones sees only the falling half of the window: 64+63+...+1.
            if (k < 10)       begin e.lo = 0;    e.hi = 0;    end
            else if (k == 10) begin e.lo = 2080; e.hi = 2080; end
            else              begin e.lo = 4095; e.hi = 4095; end
          end
          4: begin
            if (vol == 0) begin e.lo = 0; e.hi = 0; end
            else begin
              e.lo = (vol - 64 < 0) ? 0 : vol - 64;
              e.hi = (vol + 64 > 4095) ? 4095 : vol + 64;
            end
          end
          default: begin e.lo = -1; e.hi = -1; end
        endcase
        sbq.push_back(e);
      end
    end
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
    join_none
    @(negedge clk);

    do_reset(5); run(0, 8, 0);     drain();
    do_reset(5); run(1, 6, 0);     drain();
    do_reset(5); run(2, 6, 0);     drain();
    do_reset(5); run(3, 13, 0);    drain();
    do_reset(5); run(4, 6, 1000);  drain();
    do_reset(5); run(4, 6, 0);     drain();
    do_reset(5); run(4, 6, 4095);  drain();

    // Reset asserted on the edge where dcnt would be 30, during full-scale input.
    do_reset(5); run(1, 4, 0);
    for (int o = 0; o < 30; o++) begin
      snd_in = 1'b1;
      @(negedge clk);
    end
    chk("pre_rst_vol_out", int'(vol_out), 4095, 4095);
    do_reset(1);
    run(1, 4, 0);
    drain();

    chk("sb_empty", sbq.size(), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
